// File: rtl/dut_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dut_sequencer
// Description : Command-driven DUT-interface sequencer. Pops command words
//               from a show-ahead FIFO and executes them: VECTOR drives mosi,
//               waits a programmable settle time, samples miso under a mask
//               and pushes the result; other commands set the settle time,
//               the mask or the target select, or end the run.
// Revision    : 1.0 - initial release
// ============================================================================
module dut_sequencer #(
    parameter int STF_WIDTH    = 24,
    parameter int RTF_WIDTH    = 24,
    parameter int REQ_WIDTH    = 3,
    parameter int CMD_WIDTH    = 5,
    parameter int WAIT_WIDTH   = 16,
    parameter int DSEL_WIDTH   = 5,
    parameter int CNT_WIDTH    = 16,
    parameter int DEFAULT_WAIT = 2,
    parameter int DIF_WIDTH    = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  done,
    output logic                  busy,
    output logic                  bad_cmd,
    input  logic [DIF_WIDTH-1:0]  cmd_data,
    input  logic                  cmd_empty,
    output logic                  cmd_rdreq,
    output logic [RTF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_wrreq,
    input  logic                  rfifo_wrfull,
    output logic [STF_WIDTH-1:0]  mosi,
    input  logic [RTF_WIDTH-1:0]  miso,
    output logic [DSEL_WIDTH-1:0] target_sel,
    output logic [CNT_WIDTH-1:0]  vec_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_PUSH   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [REQ_WIDTH-1:0] c_REQ_VECTOR   = REQ_WIDTH'(0);
    localparam logic [REQ_WIDTH-1:0] c_REQ_SET_WAIT = REQ_WIDTH'(1);
    localparam logic [REQ_WIDTH-1:0] c_REQ_SELECT   = REQ_WIDTH'(2);
    localparam logic [REQ_WIDTH-1:0] c_REQ_SET_MASK = REQ_WIDTH'(3);
    localparam logic [REQ_WIDTH-1:0] c_REQ_END      = REQ_WIDTH'(5);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DIF_WIDTH-1:0]    r_cmd;
    logic [WAIT_WIDTH-1:0]   r_wait;
    logic [WAIT_WIDTH-1:0]   r_settle;
    logic [RTF_WIDTH-1:0]    r_mask;
    logic [RTF_WIDTH-1:0]    r_result;
    logic [STF_WIDTH-1:0]    r_mosi;
    logic [DSEL_WIDTH-1:0]   r_target_sel;
    logic                    r_done;
    logic                    r_bad_cmd;
    logic [CNT_WIDTH-1:0]    r_vec_count;

    logic [REQ_WIDTH-1:0]    w_req;
    logic                    w_drive_only;
    logic [STF_WIDTH-1:0]    w_payload;
    logic [RTF_WIDTH-1:0]    w_mask_in;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_unused_cmd_bits;

    // Latched command fields: {req, cmd, payload}, MSB first.
    assign w_req        = r_cmd[DIF_WIDTH-1 -: REQ_WIDTH];
    assign w_drive_only = r_cmd[STF_WIDTH];
    assign w_payload    = r_cmd[STF_WIDTH-1:0];

    // Only cmd[0] carries meaning today; the upper modifier bits are reserved.
    assign w_unused_cmd_bits = |r_cmd[STF_WIDTH+1 +: CMD_WIDTH-1];

    // Mask payload fitted to the result width.
    generate
        if (RTF_WIDTH <= STF_WIDTH) begin : g_mask_trunc
            assign w_mask_in = w_payload[RTF_WIDTH-1:0];
        end else begin : g_mask_ext
            assign w_mask_in = {{(RTF_WIDTH-STF_WIDTH){1'b0}}, w_payload};
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the FIFO pop and push strobes.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end else if (!cmd_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_req)
                    c_REQ_VECTOR: w_next_state = ST_SETTLE;
                    c_REQ_END:    w_next_state = ST_DONE;
                    default:      w_next_state = ST_FETCH;
                endcase
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_next_state = w_drive_only ? ST_FETCH : ST_PUSH;
            end
            ST_PUSH: begin
                if (!rfifo_wrfull) begin
                    w_push       = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: command latch, configuration registers, sample and counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cmd        <= '0;
            r_wait       <= WAIT_WIDTH'(DEFAULT_WAIT);
            r_settle     <= '0;
            r_mask       <= '1;
            r_result     <= '0;
            r_mosi       <= '0;
            r_target_sel <= '0;
            r_done       <= 1'b0;
            r_bad_cmd    <= 1'b0;
            r_vec_count  <= '0;
        end else begin
            if (w_pop) begin
                r_cmd <= cmd_data;
            end
            case (r_state)
                ST_EXEC: begin
                    case (w_req)
                        c_REQ_VECTOR: begin
                            r_mosi   <= w_payload;
                            r_settle <= r_wait;
                        end
                        c_REQ_SET_WAIT: r_wait       <= w_payload[WAIT_WIDTH-1:0];
                        c_REQ_SELECT:   r_target_sel <= w_payload[DSEL_WIDTH-1:0];
                        c_REQ_SET_MASK: r_mask       <= w_mask_in;
                        c_REQ_END:      r_done       <= 1'b1;
                        default:        r_bad_cmd    <= 1'b1;
                    endcase
                end
                ST_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - WAIT_WIDTH'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_result <= miso & r_mask;
                end
                ST_PUSH: begin
                    if (w_push) begin
                        r_vec_count <= r_vec_count + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so nothing leaves the block in a reset cycle.
    assign cmd_rdreq   = w_pop & reset_n;
    assign rfifo_wrreq = w_push & reset_n;
    assign rfifo_data  = r_result;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done        = r_done;
    assign bad_cmd     = r_bad_cmd;
    assign mosi        = r_mosi;
    assign target_sel  = r_target_sel;
    assign vec_count   = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_dut_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dut_sequencer
// Description : Self-checking bench for dut_sequencer: table of single
//               commands with expected outputs and latencies, a result
//               scoreboard, and hand-written multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dut_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] cmd_data;
    logic        cmd_empty;
    logic        rfifo_wrfull;
    logic        miso_inv;
    logic [23:0] miso_val;
    logic [23:0] miso;

    logic        done, busy, bad_cmd, cmd_rdreq, rfifo_wrreq;
    logic [23:0] rfifo_data, mosi;
    logic [4:0]  target_sel;
    logic [15:0] vec_count;

    logic        unused_done, unused_busy, unused_bad, unused_rd, unused_wr;
    logic [23:0] unused_data, unused_mosi;
    logic [4:0]  unused_sel;
    logic [3:0]  n_vec_count;

    assign miso = miso_inv ? ~mosi : miso_val;

    always #5 clock = ~clock;

    dut_sequencer u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .done(done), .busy(busy), .bad_cmd(bad_cmd),
        .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_rdreq(cmd_rdreq),
        .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
        .mosi(mosi), .miso(miso), .target_sel(target_sel), .vec_count(vec_count)
    );

    // Narrow-counter twin sharing every input, used to observe counter wrap.
    dut_sequencer #(.CNT_WIDTH(4)) u_dut_narrow (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .done(unused_done), .busy(unused_busy), .bad_cmd(unused_bad),
        .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_rdreq(unused_rd),
        .rfifo_data(unused_data), .rfifo_wrreq(unused_wr), .rfifo_wrfull(rfifo_wrfull),
        .mosi(unused_mosi), .miso(miso), .target_sel(unused_sel), .vec_count(n_vec_count)
    );

    typedef struct {
        logic [2:0]  req;
        logic [4:0]  cmd;
        logic [23:0] pl;
        logic        inv;
        logic [23:0] mi;
        logic        wr;
        logic [23:0] data;
        int          lat;
        logic [23:0] mosi;
        logic [4:0]  sel;
        logic [15:0] cnt;
        logic        bad;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    logic [31:0] cmd_q [$];
    logic [23:0] exp_q [$];
    int          pop_cyc [$];
    int          wr_cyc [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    int          s_cyc;
    logic        s_rd, s_wr, s_done, s_busy, s_bad, prev_rd, prev_wr;
    logic [23:0] s_data, s_mosi;
    logic [4:0]  s_sel;
    logic [15:0] s_cnt;
    logic [3:0]  s_ncnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] w);
        cmd_q.push_back(w);
        cmd_empty = 1'b0;
        cmd_data  = cmd_q[0];
    endtask

    // One clock: sample at the falling edge, act on FIFO strobes after the rise.
    task automatic tick();
        logic [31:0] tmp;
        logic [23:0] e;
        @(negedge clock);
        s_cyc  = cyc;
        s_rd   = cmd_rdreq;
        s_wr   = rfifo_wrreq;
        s_data = rfifo_data;
        s_mosi = mosi;
        s_sel  = target_sel;
        s_done = done;
        s_busy = busy;
        s_bad  = bad_cmd;
        s_cnt  = vec_count;
        s_ncnt = n_vec_count;
        if (s_rd) begin
            pop_cyc.push_back(cyc);
            if (cmd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pop_empty: cmd_rdreq=1 at cycle %0d with empty FIFO", cyc);
            end
        end
        if ((s_rd && prev_rd) || (s_wr && prev_wr)) begin
            total++; bad++;
            $display("FAIL strobe_width: rdreq=%0b wrreq=%0b high two cycles at %0d, want single", s_rd, s_wr, cyc);
        end
        prev_rd = s_rd;
        prev_wr = s_wr;
        if (s_wr) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: data 0x%0h at cycle %0d, want no write", s_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", {8'h0, s_data}, {8'h0, e});
            end
        end
        @(posedge clock);
        #1;
        if (s_rd && cmd_q.size() > 0) tmp = cmd_q.pop_front();
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = cmd_empty ? 32'h0 : cmd_q[0];
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] prev_mosi;
        logic [4:0]  prev_sel;
        logic [23:0] pl;
        logic        mosi_ok;
        int          pidx, widx, p;

        //        req   cmd    payload      inv   miso        wr    data        lat mosi        sel    cnt    bad
        tbl[0]  = '{3'd0, 5'd0, 24'h00A5A5, 1'b1, 24'h000000, 1'b1, 24'hFF5A5A, 6, 24'h00A5A5, 5'h00, 16'd1, 1'b0};
        tbl[1]  = '{3'd1, 5'd0, 24'h000000, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h00A5A5, 5'h00, 16'd1, 1'b0};
        tbl[2]  = '{3'd3, 5'd0, 24'h0000FF, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h00A5A5, 5'h00, 16'd1, 1'b0};
        tbl[3]  = '{3'd0, 5'd0, 24'h123456, 1'b0, 24'hABCDEF, 1'b1, 24'h0000EF, 4, 24'h123456, 5'h00, 16'd2, 1'b0};
        tbl[4]  = '{3'd0, 5'd1, 24'h654321, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 0, 24'h654321, 5'h00, 16'd2, 1'b0};
        tbl[5]  = '{3'd2, 5'd0, 24'h000013, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h654321, 5'h13, 16'd2, 1'b0};
        tbl[6]  = '{3'd1, 5'd0, 24'h000005, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h654321, 5'h13, 16'd2, 1'b0};
        tbl[7]  = '{3'd3, 5'd0, 24'hF0F0F0, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h654321, 5'h13, 16'd2, 1'b0};
        tbl[8]  = '{3'd0, 5'd2, 24'h0F0F0F, 1'b0, 24'h5AA5C3, 1'b1, 24'h50A0C0, 9, 24'h0F0F0F, 5'h13, 16'd3, 1'b0};
        tbl[9]  = '{3'd6, 5'd0, 24'h000000, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h0F0F0F, 5'h13, 16'd3, 1'b1};
        tbl[10] = '{3'd1, 5'd0, 24'hAB0003, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h0F0F0F, 5'h13, 16'd3, 1'b1};
        tbl[11] = '{3'd3, 5'd0, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'h0F0F0F, 5'h13, 16'd3, 1'b1};
        tbl[12] = '{3'd0, 5'd0, 24'hFFFFFF, 1'b0, 24'h000001, 1'b1, 24'h000001, 7, 24'hFFFFFF, 5'h13, 16'd4, 1'b1};
        tbl[13] = '{3'd4, 5'd0, 24'h123456, 1'b0, 24'h000000, 1'b0, 24'h000000, 0, 24'hFFFFFF, 5'h13, 16'd4, 1'b1};

        reset_n = 1'b0; enable = 1'b0; cmd_empty = 1'b1; cmd_data = 32'h0;
        rfifo_wrfull = 1'b0; miso_inv = 1'b0; miso_val = 24'h0;
        prev_rd = 1'b0; prev_wr = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("rst_done", s_done, 0);  chk("rst_busy", s_busy, 0);  chk("rst_bad", s_bad, 0);
        chk("rst_rdreq", s_rd, 0);   chk("rst_wrreq", s_wr, 0);   chk("rst_mosi", s_mosi, 0);
        chk("rst_sel", s_sel, 0);    chk("rst_cnt", s_cnt, 0);
        reset_n = 1'b1; enable = 1'b1;

        // Single-command table: timing of pop, mosi/target_sel update and write.
        prev_mosi = 24'h0; prev_sel = 5'h0;
        for (int i = 0; i < NV; i++) begin
            miso_inv = tbl[i].inv; miso_val = tbl[i].mi;
            if (tbl[i].wr) exp_q.push_back(tbl[i].data);
            push_cmd({tbl[i].req, tbl[i].cmd, tbl[i].pl});
            pidx = pop_cyc.size(); widx = wr_cyc.size();
            for (int k = 0; k < 25; k++) begin
                tick();
                if (pop_cyc.size() > pidx) begin
                    p = pop_cyc[pidx];
                    if (s_cyc == p + 1) begin
                        chk($sformatf("v%0d_mosi_hold", i), s_mosi, prev_mosi);
                        chk($sformatf("v%0d_sel_hold", i), s_sel, prev_sel);
                    end
                    if (s_cyc == p + 2) begin
                        chk($sformatf("v%0d_mosi_t2", i), s_mosi, tbl[i].mosi);
                        chk($sformatf("v%0d_sel_t2", i), s_sel, tbl[i].sel);
                    end
                end
            end
            chk($sformatf("v%0d_pops", i), pop_cyc.size() - pidx, 1);
            chk($sformatf("v%0d_writes", i), wr_cyc.size() - widx, tbl[i].wr);
            if (tbl[i].wr && wr_cyc.size() > widx && pop_cyc.size() > pidx)
                chk($sformatf("v%0d_latency", i), wr_cyc[widx] - pop_cyc[pidx], tbl[i].lat);
            chk($sformatf("v%0d_cnt", i), s_cnt, tbl[i].cnt);
            chk($sformatf("v%0d_bad", i), s_bad, tbl[i].bad);
            chk($sformatf("v%0d_busy", i), s_busy, 1);
            chk($sformatf("v%0d_mosi_end", i), s_mosi, tbl[i].mosi);
            prev_mosi = tbl[i].mosi; prev_sel = tbl[i].sel;
        end

        // Back-to-back non-vector commands pop every 2 cycles.
        pidx = pop_cyc.size();
        push_cmd({3'd1, 5'd0, 24'h000001});
        push_cmd({3'd2, 5'd0, 24'h000007});
        push_cmd({3'd1, 5'd0, 24'h000000});
        for (int k = 0; k < 12; k++) tick();
        chk("b2b_pops", pop_cyc.size() - pidx, 3);
        if (pop_cyc.size() >= pidx + 3) begin
            chk("b2b_gap1", pop_cyc[pidx+1] - pop_cyc[pidx], 2);
            chk("b2b_gap2", pop_cyc[pidx+2] - pop_cyc[pidx+1], 2);
        end
        chk("b2b_sel", s_sel, 5'h07);

        // Result FIFO full across PUSH: no write, no pop, mosi stable.
        rfifo_wrfull = 1'b1; miso_inv = 1'b0; miso_val = 24'h123456;
        exp_q.push_back(24'h123456);
        pidx = pop_cyc.size(); widx = wr_cyc.size();
        push_cmd({3'd0, 5'd0, 24'h0000AA});
        push_cmd({3'd2, 5'd0, 24'h000001});
        for (int k = 0; k < 8 && pop_cyc.size() == pidx; k++) tick();
        p = s_cyc; mosi_ok = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (s_cyc >= p + 2 && s_mosi !== 24'h0000AA) mosi_ok = 1'b0;
        end
        chk("stall_writes", wr_cyc.size() - widx, 0);
        chk("stall_pops", pop_cyc.size() - pidx, 1);
        rfifo_wrfull = 1'b0;
        tick();
        chk("stall_release_wr", s_wr, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (s_mosi !== 24'h0000AA) mosi_ok = 1'b0;
        end
        chk("stall_mosi_stable", mosi_ok, 1);
        chk("stall_total_writes", wr_cyc.size() - widx, 1);
        if (wr_cyc.size() > widx && pop_cyc.size() > pidx + 1) begin
            chk("stall_wr_cycle", wr_cyc[widx] - pop_cyc[pidx], 15);
            chk("stall_next_pop", pop_cyc[pidx+1] - pop_cyc[pidx], 16);
        end
        chk("stall_sel", s_sel, 5'h01);
        chk("stall_cnt", s_cnt, 16'd5);

        // END: done held, no more pops, cleared when enable falls.
        pidx = pop_cyc.size();
        push_cmd({3'd5, 5'd0, 24'h000000});
        push_cmd({3'd0, 5'd1, 24'h000001});
        for (int k = 0; k < 8 && pop_cyc.size() == pidx; k++) tick();
        tick();
        chk("end_exec_busy", s_busy, 1);
        tick();
        chk("end_done", s_done, 1);
        chk("end_busy", s_busy, 0);
        for (int k = 0; k < 10; k++) tick();
        chk("end_no_pop", pop_cyc.size() - pidx, 1);
        chk("end_done_held", s_done, 1);
        enable = 1'b0;
        tick();
        tick();
        chk("end_done_clear", s_done, 0);
        chk("end_idle_busy", s_busy, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("end_disabled_no_pop", pop_cyc.size() - pidx, 1);
        chk("end_bad_sticky", s_bad, 1);
        cmd_q.delete(); cmd_empty = 1'b1; cmd_data = 32'h0;

        // Reset during SETTLE abandons the vector and restores wait/mask.
        enable = 1'b1;
        pidx = pop_cyc.size();
        push_cmd({3'd3, 5'd0, 24'h00000F});
        push_cmd({3'd1, 5'd0, 24'h000008});
        push_cmd({3'd0, 5'd0, 24'h00BEEF});
        for (int k = 0; k < 20 && pop_cyc.size() < pidx + 3; k++) tick();
        for (int k = 0; k < 3; k++) tick();
        chk("rst2_mosi_settle", s_mosi, 24'h00BEEF);
        reset_n = 1'b0;
        tick();
        chk("rst2_settle_busy", s_busy, 1);
        tick();
        chk("rst2_mosi", s_mosi, 0);  chk("rst2_sel", s_sel, 0);   chk("rst2_done", s_done, 0);
        chk("rst2_busy", s_busy, 0);  chk("rst2_bad", s_bad, 0);   chk("rst2_rd", s_rd, 0);
        chk("rst2_wr", s_wr, 0);      chk("rst2_cnt", s_cnt, 0);
        tick();
        reset_n = 1'b1;
        miso_val = 24'hC3C3C3;
        exp_q.push_back(24'hC3C3C3);
        pidx = pop_cyc.size(); widx = wr_cyc.size();
        push_cmd({3'd0, 5'd0, 24'h0F0F0F});
        for (int k = 0; k < 14; k++) tick();
        if (wr_cyc.size() > widx && pop_cyc.size() > pidx)
            chk("rst2_wait_default_lat", wr_cyc[widx] - pop_cyc[pidx], 6);
        chk("rst2_one_write", wr_cyc.size() - widx, 1);
        chk("rst2_cnt_after", s_cnt, 1);

        // Counter wrap, observed on the 4-bit twin.
        miso_inv = 1'b1;
        push_cmd({3'd1, 5'd0, 24'h000000});
        for (int i = 0; i < 15; i++) begin
            pl = 24'h010203 * 24'(i + 1);
            exp_q.push_back(~pl);
            push_cmd({3'd0, 5'd0, pl});
        end
        for (int k = 0; k < 120; k++) tick();
        chk("wrap_cnt16", s_cnt, 16'd16);
        chk("wrap_narrow_zero", s_ncnt, 4'd0);
        exp_q.push_back(~24'h00FF00);
        push_cmd({3'd0, 5'd0, 24'h00FF00});
        for (int k = 0; k < 15; k++) tick();
        chk("wrap_cnt17", s_cnt, 16'd17);
        chk("wrap_narrow_one", s_ncnt, 4'd1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dut_sequencer.md
# dut_sequencer

Single-clock, parametrised successor to the tester's DUT-interface path. It fetches command words from a show-ahead FIFO and executes them against the selected target design. Vector commands drive `mosi`, wait a programmable settle time, sample `miso` under a programmable mask and push the result into the result FIFO. Other commands change the settle time, the mask or the target select, or end the run, so one command stream replaces the fixed stimulus/result pairing of the previous generation.

## Interface
- `STF_WIDTH`, 24, stimulus (mosi) width and command payload width
- `RTF_WIDTH`, 24, response (miso) and result width
- `REQ_WIDTH`, 3, request-code field width
- `CMD_WIDTH`, 5, command-modifier field width (REQ_WIDTH+CMD_WIDTH <= 8)
- `WAIT_WIDTH`, 16, settle counter width
- `DSEL_WIDTH`, 5, target select width
- `CNT_WIDTH`, 16, pushed-result counter width
- `DEFAULT_WAIT`, 2, settle value after reset
- `DIF_WIDTH`, REQ_WIDTH+CMD_WIDTH+STF_WIDTH, command word width (derived)

Ports:
- `clock` in 1: the only clock
- `reset_n` in 1: synchronous, active-low reset
- `enable` in 1: level; run while high
- `done` out 1: set by END, held until `enable` falls
- `busy` out 1: high in every state except IDLE and DONE
- `bad_cmd` out 1: sticky; set by an unknown request code; cleared only by reset
- `cmd_data` in DIF_WIDTH: {req, cmd, payload}, MSB first; valid while `!cmd_empty` (show-ahead)
- `cmd_empty` in 1: command FIFO empty
- `cmd_rdreq` out 1: one-cycle pop
- `rfifo_data` out RTF_WIDTH: masked result
- `rfifo_wrreq` out 1: result write strobe
- `rfifo_wrfull` in 1: result FIFO full
- `mosi` out STF_WIDTH: stimulus to the DUT, registered
- `miso` in RTF_WIDTH: response from the DUT
- `target_sel` out DSEL_WIDTH: selected target design, registered
- `vec_count` out CNT_WIDTH: number of results pushed

## Operation
- States: IDLE, FETCH, EXEC, SETTLE, SAMPLE, PUSH, DONE.
- IDLE: if `enable` → FETCH.
- FETCH:
  - if `!enable` → IDLE;
  - else if `!cmd_empty`: pulse `cmd_rdreq`, latch `cmd_data` → EXEC;
  - else stay.
- EXEC, by request code:
  - 0 VECTOR: `mosi`<=payload; settle counter <= wait register → SETTLE.
  - 1 SET_WAIT: wait register <= payload[WAIT_WIDTH-1:0] → FETCH.
  - 2 SELECT: `target_sel`<=payload[DSEL_WIDTH-1:0] → FETCH.
  - 3 SET_MASK: mask <= payload, zero-extended or truncated to RTF_WIDTH → FETCH.
  - 5 END: `done`<=1 → DONE.
  - 4, 6, 7: `bad_cmd`<=1 → FETCH (command discarded).
- SETTLE: if counter==0 → SAMPLE, else counter-1. SETTLE therefore lasts wait+1 cycles.
- SAMPLE:
  - result <= `miso` & mask.
  - If cmd[0]==1 (drive-only): no push → FETCH.
  - Else → PUSH.
- PUSH:
  - `rfifo_wrreq` = (state==PUSH && !`rfifo_wrfull`), combinational; `rfifo_data`=result.
  - On the write: `vec_count`+1, wrapping at 2^CNT_WIDTH → FETCH.
  - While full: stay in PUSH with no write.
- DONE: hold `done`=1; when `enable`==0, clear `done` → IDLE.
- `mosi` and `target_sel` keep their values between commands and across IDLE.
- `enable` falling mid-command: the current command runs to completion (including a stalled PUSH), then FETCH → IDLE. No pop happens while `enable` is low.

## Timing
- Reset values (the edge where `reset_n`=0): state IDLE, `mosi`=0, `target_sel`=0, `done`=0, `busy`=0, `bad_cmd`=0, `cmd_rdreq`=0, `rfifo_wrreq`=0, `vec_count`=0, wait=DEFAULT_WAIT, mask all ones.
- Reset mid-operation: abandon the command; no further pop or write. A popped but unexecuted command is lost.
- VECTOR with wait W, FIFOs not stalled, pop at cycle t:
  - EXEC at t+1; `mosi` valid from t+2.
  - SETTLE t+2..t+2+W.
  - SAMPLE at t+3+W; `miso` is sampled W+1 cycles after `mosi` changes.
  - `rfifo_wrreq` at t+4+W; next pop at t+5+W.
- Non-vector commands: 2 cycles each (FETCH+EXEC); back-to-back pops are spaced 2 cycles apart.
- `cmd_rdreq` and `rfifo_wrreq` are never high for more than one consecutive cycle per command.
- A SET_WAIT or SET_MASK takes effect from the next VECTOR, never the one in flight.

## Test plan
- Reset, `enable`=1, FIFO holds VECTOR payload 0x00A5A5 (cmd=0), `miso`=~mosi → `mosi`=0x00A5A5 at t+2; `rfifo_data`=0xFF5A5A with `rfifo_wrreq` at t+6 (W=2); `vec_count`=1.
- SET_WAIT 0, then SET_MASK 0x0000FF, then VECTOR 0x123456 with `miso`=0xABCDEF → `rfifo_data`=0x0000EF with wrreq exactly 4 cycles after the VECTOR pop.
- VECTOR with cmd=1 → `mosi` updates, no `rfifo_wrreq`, `vec_count` unchanged. Then SELECT 0x13 → `target_sel`=0x13 two cycles after the pop.
- `rfifo_wrfull` held for 10 cycles during PUSH → no write and no pop. Single write the cycle after full drops; `mosi` stable throughout.
- END → `done`=1, `busy`=0, no further pops despite a non-empty FIFO; `enable` low → `done`=0, IDLE. Request code 6 → `bad_cmd` stays 1 until reset.
- Assert `reset_n`=0 during SETTLE → next cycle all outputs at reset values; wait back to 2, mask all ones; `vec_count` wraps 0xFFFF→0 after 65536 pushes (CNT_WIDTH=16).
